// File: rtl/rr_arbiter_ctrl.sv
// rr_arbiter_ctrl: round-robin grant controller for one shared resource.
// Grants are registered and one-hot. A grant is held until the grantee
// signals done, withdraws its request, or uses up MAX_HOLD cycles while
// someone else waits. On release the pointer moves past the old grantee
// and a new grant is chosen on the same edge, so there is no idle cycle.
`timescale 1ns/1ps

module rr_arbiter_ctrl #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDX_W   = ($clog2(N) > 1) ? $clog2(N) : 1,
    localparam int CNT_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic             iClk,
    input  logic             iRstN,
    input  logic [N-1:0]     iRequest,
    input  logic             iDone,
    output logic [N-1:0]     oGrant,
    output logic             oGrantValid,
    output logic [IDX_W-1:0] oGrantIdx
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q,     state_d;
    logic [N-1:0]     grant_q,     grant_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] ptr_q,       ptr_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic [IDX_W-1:0] ptr_after;      // pointer value just past the current grantee
    logic [IDX_W-1:0] arb_ptr;        // pointer used for this edge's selection
    logic [IDX_W-1:0] sel_idx;        // winner of the rotated fixed-priority pick
    logic             any_req;
    logic             others_waiting;
    logic             hold_expired;
    logic             rel_grant;      // current grant ends on this edge

    // Lowest set bit at or above start; falls back to the lowest set bit overall.
    function automatic logic [IDX_W-1:0] pick(input logic [N-1:0]     req,
                                              input logic [IDX_W-1:0] start);
        logic [N-1:0]     masked;
        logic [IDX_W-1:0] idx;
        logic             found;
        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] && (i >= int'(start));
        end
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (masked[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign any_req        = |iRequest;
    assign others_waiting = |(iRequest & ~grant_q);
    assign hold_expired   = (cnt_q == CNT_W'(MAX_HOLD));
    assign ptr_after      = (grant_idx_q == IDX_W'(N - 1)) ? '0 : grant_idx_q + 1'b1;
    assign rel_grant      = iDone || !iRequest[grant_idx_q] || (hold_expired && others_waiting);
    assign arb_ptr        = (state_q == GRANT) ? ptr_after : ptr_q;
    assign sel_idx        = pick(iRequest, arb_ptr);

    // State and datapath registers; reset clears the grant immediately.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state: leave IDLE on any request, return only when a release finds nobody.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = GRANT;
            GRANT:   if (rel_grant && !any_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next grant, index, pointer and tenure counter.
    always_comb begin
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    grant_idx_d      = sel_idx;
                    cnt_d            = CNT_W'(1);
                end
            end
            GRANT: begin
                if (rel_grant) begin
                    ptr_d = ptr_after;
                    if (any_req) begin
                        grant_d          = '0;
                        grant_d[sel_idx] = 1'b1;
                        grant_idx_d      = sel_idx;
                        cnt_d            = CNT_W'(1);
                    end else begin
                        grant_d     = '0;
                        grant_idx_d = '0;
                        cnt_d       = '0;
                    end
                end else if (!hold_expired) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                grant_d     = '0;
                grant_idx_d = '0;
                cnt_d       = '0;
            end
        endcase
    end

    assign oGrant      = grant_q;
    assign oGrantValid = |grant_q;
    assign oGrantIdx   = grant_idx_q;

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Testbench for rr_arbiter_ctrl: directed scenarios plus a randomized run,
// all compared against a rotation-based behavioural model of the arbiter.
`timescale 1ns/1ps

module tb_rr_arbiter_ctrl;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int IW       = 2;

    logic          iClk = 1'b0;
    logic          iRstN;
    logic [N-1:0]  iRequest;
    logic          iDone;
    logic [N-1:0]  oGrant;
    logic          oGrantValid;
    logic [IW-1:0] oGrantIdx;

    int checks   = 0;
    int failures = 0;

    // Model: current owner (-1 when none), cycles held so far, and the
    // requester that gets first look at the next arbitration.
    int m_owner;
    int m_tenure;
    int m_start;

    rr_arbiter_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .iClk        (iClk),
        .iRstN       (iRstN),
        .iRequest    (iRequest),
        .iDone       (iDone),
        .oGrant      (oGrant),
        .oGrantValid (oGrantValid),
        .oGrantIdx   (oGrantIdx)
    );

    always #5 iClk = ~iClk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Walk the requesters in rotation order starting at 'start'.
    function automatic int rotate_pick(input logic [N-1:0] req, input int start);
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_grant();
        return (m_owner >= 0) ? N'(1 << m_owner) : '0;
    endfunction

    function automatic logic [IW-1:0] model_idx();
        return (m_owner >= 0) ? IW'(m_owner) : '0;
    endfunction

    function automatic logic model_valid();
        return m_owner >= 0;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_tenure = 0;
        m_start  = 0;
    endtask

    // One clock edge of the arbitration rules.
    task automatic model_edge(input logic [N-1:0] req, input logic done);
        int  others;
        bit  ends;
        if (m_owner < 0) begin
            if (req != '0) begin
                m_owner  = rotate_pick(req, m_start);
                m_tenure = 1;
            end
        end else begin
            others = int'(req) & ~(1 << m_owner);
            ends   = done || !req[m_owner] || (m_tenure >= MAX_HOLD && others != 0);
            if (ends) begin
                m_start = (m_owner + 1) % N;
                if (req != '0) begin
                    m_owner  = rotate_pick(req, m_start);
                    m_tenure = 1;
                end else begin
                    m_owner  = -1;
                    m_tenure = 0;
                end
            end else if (m_tenure < MAX_HOLD) begin
                m_tenure++;
            end
        end
    endtask

    // Drive inputs, take one edge, advance the model, settle 1ns past the edge.
    task automatic tick(input logic [N-1:0] req, input logic done);
        iRequest = req;
        iDone    = done;
        @(posedge iClk);
        model_edge(req, done);
        #1;
    endtask

    task automatic do_reset();
        iRstN    = 1'b0;
        iRequest = '0;
        iDone    = 1'b0;
        model_reset();
        @(posedge iClk);
        @(posedge iClk);
        #1;
        iRstN = 1'b1;
    endtask

    task automatic test_reset();
        iRstN    = 1'b0;
        iRequest = 4'b1111;
        iDone    = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (oGrant !== '0 || oGrantValid !== 1'b0 || oGrantIdx !== '0) begin
                failures++;
                $display("FAIL reset_hold[%0d]: got grant=%b valid=%b idx=%0d, need all zero",
                         i, oGrant, oGrantValid, oGrantIdx);
            end
            @(posedge iClk);
            #1;
        end
        iRequest = '0;
        iRstN    = 1'b1;
        tick(4'b0000, 1'b0);
        checks++;
        if (oGrant !== '0 || oGrantValid !== 1'b0 || oGrantIdx !== '0) begin
            failures++;
            $display("FAIL reset_release: got grant=%b valid=%b idx=%0d, need all zero",
                     oGrant, oGrantValid, oGrantIdx);
        end
        tick(4'b1111, 1'b0);
        tick(4'b1111, 1'b0);
        checks++;
        if (oGrant !== 4'b0001) begin
            failures++;
            $display("FAIL pre_async_grant: got grant=%b, need 0001", oGrant);
        end
        // Mid-cycle asynchronous reset while a grant is active.
        #3;
        iRstN = 1'b0;
        #1;
        checks++;
        if (oGrant !== '0 || oGrantValid !== 1'b0 || oGrantIdx !== '0) begin
            failures++;
            $display("FAIL async_reset: got grant=%b valid=%b idx=%0d before next edge, need all zero",
                     oGrant, oGrantValid, oGrantIdx);
        end
        model_reset();
        @(posedge iClk);
        #1;
        iRstN = 1'b1;
        tick(4'b1111, 1'b0);
        checks++;
        if (oGrant !== 4'b0001 || oGrantIdx !== 2'd0 || oGrantValid !== 1'b1) begin
            failures++;
            $display("FAIL first_grant_after_reset: got grant=%b idx=%0d valid=%b, need 0001 idx=0 valid=1",
                     oGrant, oGrantIdx, oGrantValid);
        end
    endtask

    task automatic test_handover();
        do_reset();
        tick(4'b1010, 1'b0);
        checks++;
        if (oGrant !== 4'b0010 || oGrantIdx !== 2'd1 || oGrantValid !== 1'b1) begin
            failures++;
            $display("FAIL handover_first: got grant=%b idx=%0d, need 0010 idx=1", oGrant, oGrantIdx);
        end
        tick(4'b1010, 1'b1);
        checks++;
        if (oGrant !== 4'b1000 || oGrantIdx !== 2'd3 || oGrantValid !== 1'b1) begin
            failures++;
            $display("FAIL handover_second: got grant=%b idx=%0d valid=%b, need 1000 idx=3 valid=1",
                     oGrant, oGrantIdx, oGrantValid);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(4'b1111, 1'b1);
            checks++;
            if (oGrantIdx !== IW'(i % N) || oGrant !== model_grant() || oGrantValid !== 1'b1) begin
                failures++;
                $display("FAIL fairness[%0d]: got idx=%0d grant=%b, need idx=%0d grant=%b",
                         i, oGrantIdx, oGrant, i % N, model_grant());
            end
        end
    endtask

    task automatic test_hold_timeout();
        logic [N-1:0] want;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            tick(4'b0011, 1'b0);
            want = (i < 8 || i >= 16) ? 4'b0001 : 4'b0010;
            checks++;
            if (oGrant !== want || oGrant !== model_grant()) begin
                failures++;
                $display("FAIL hold_timeout[%0d]: got grant=%b, need %b", i, oGrant, want);
            end
        end
        // Lone requester keeps the grant; its counter must saturate, so a
        // newcomer after a long hold forces release on the very next edge.
        do_reset();
        for (int i = 0; i < 22; i++) begin
            tick(4'b0001, 1'b0);
            checks++;
            if (oGrant !== 4'b0001) begin
                failures++;
                $display("FAIL lone_hold[%0d]: got grant=%b, need 0001", i, oGrant);
            end
        end
        tick(4'b0011, 1'b0);
        checks++;
        if (oGrant !== 4'b0010 || oGrantIdx !== 2'd1) begin
            failures++;
            $display("FAIL saturated_release: got grant=%b idx=%0d, need 0010 idx=1", oGrant, oGrantIdx);
        end
    endtask

    task automatic test_withdrawal();
        do_reset();
        tick(4'b0100, 1'b0);
        tick(4'b0000, 1'b0);
        checks++;
        if (oGrant !== '0 || oGrantValid !== 1'b0 || oGrantIdx !== '0) begin
            failures++;
            $display("FAIL withdraw_idle: got grant=%b valid=%b idx=%0d, need all zero",
                     oGrant, oGrantValid, oGrantIdx);
        end
        tick(4'b0101, 1'b0);
        checks++;
        if (oGrant !== 4'b0001) begin
            failures++;
            $display("FAIL withdraw_wrap: got grant=%b, need 0001", oGrant);
        end
        // Same withdrawal, then a pattern where pointer 3 must beat bit 2.
        do_reset();
        tick(4'b0100, 1'b0);
        tick(4'b0000, 1'b0);
        tick(4'b1100, 1'b0);
        checks++;
        if (oGrant !== 4'b1000 || oGrantIdx !== 2'd3) begin
            failures++;
            $display("FAIL withdraw_ptr3: got grant=%b idx=%0d, need 1000 idx=3", oGrant, oGrantIdx);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick(4'b0100, 1'b0);
        tick(4'b1001, 1'b1);
        checks++;
        if (oGrant !== 4'b1000 || oGrantIdx !== 2'd3 || oGrantValid !== 1'b1) begin
            failures++;
            $display("FAIL simultaneous_release: got grant=%b idx=%0d, need 1000 idx=3", oGrant, oGrantIdx);
        end
        // Pointer is now 0 after grantee 3; done plus withdrawal of 3 goes to 0.
        tick(4'b0011, 1'b1);
        checks++;
        if (oGrant !== 4'b0001) begin
            failures++;
            $display("FAIL simultaneous_follow: got grant=%b, need 0001", oGrant);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] req;
        logic         done;
        do_reset();
        req = '0;
        for (int i = 0; i < 400; i++) begin
            // Mostly keep requests steady so tenure limits get exercised.
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, (1 << N) - 1));
            done = ($urandom_range(0, 5) == 0);
            tick(req, done);
            checks++;
            if (oGrant !== model_grant() || oGrantValid !== model_valid() || oGrantIdx !== model_idx()) begin
                failures++;
                $display("FAIL random[%0d] req=%b done=%b: got grant=%b valid=%b idx=%0d, need grant=%b valid=%b idx=%0d",
                         i, req, done, oGrant, oGrantValid, oGrantIdx,
                         model_grant(), model_valid(), model_idx());
            end
        end
    endtask

    initial begin
        iRstN    = 1'b0;
        iRequest = '0;
        iDone    = 1'b0;
        model_reset();
        test_reset();
        test_handover();
        test_fairness();
        test_hold_timeout();
        test_withdrawal();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
